// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - two-port round-robin sequencer for the shared iterative multiplier
module mult_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [31:0] r0_acc,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [31:0] r1_acc,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        mul_start,
    output logic [31:0] mul_in0,
    output logic [31:0] mul_in1,
    output logic [31:0] mul_acc0,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;      // 1: requester 1 wins a tie
    logic        id_q, id_d;
    logic [31:0] in0_q, in0_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] acc0_q, acc0_d;
    logic [31:0] result_q, result_d;

    logic        grant0;
    logic        grant1;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic [31:0] sel_acc;

    // State register: all flops, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            in0_q    <= 32'd0;
            in1_q    <= 32'd0;
            acc0_q   <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            in0_q    <= in0_d;
            in1_q    <= in1_d;
            acc0_q   <= acc0_d;
            result_q <= result_d;
        end
    end

    // Next state: acceptance with zero-skip and operand ordering, start, wait, response
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        id_d     = id_q;
        in0_d    = in0_q;
        in1_d    = in1_q;
        acc0_d   = acc0_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    id_d   = grant1;
                    // The requester just served loses the next tie
                    prio_d = grant0;
                    if ((sel_a == 32'd0) || (sel_b == 32'd0)) begin
                        // Product is zero: result is the accumulator, multiplier untouched
                        result_d = sel_acc;
                        state_d  = RESP;
                    end else begin
                        // Smaller operand drives the iteration count
                        in0_d   = (sel_a < sel_b) ? sel_a : sel_b;
                        in1_d   = (sel_a < sel_b) ? sel_b : sel_a;
                        acc0_d  = sel_acc;
                        state_d = START;
                    end
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    result_d = mul_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: round-robin grant, operand select, handshakes and multiplier drive
    always_comb begin
        grant0     = (state_q == IDLE) && r0_valid && (!r1_valid || !prio_q);
        grant1     = (state_q == IDLE) && r1_valid && !grant0;
        sel_a      = grant1 ? r1_a   : r0_a;
        sel_b      = grant1 ? r1_b   : r0_b;
        sel_acc    = grant1 ? r1_acc : r0_acc;
        r0_ready   = grant0 && !rst;
        r1_ready   = grant1 && !rst;
        rsp_valid  = (state_q == RESP);
        rsp_id     = id_q;
        rsp_result = result_q;
        mul_start  = (state_q == START);
        mul_in0    = in0_q;
        mul_in1    = in1_q;
        mul_acc0   = acc0_q;
        busy       = (state_q != IDLE);
    end

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - scoreboard bench for mult_sched with a behavioural radix-4 multiplier
module tb_mult_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [31:0] r0_a, r0_b, r0_acc, r1_a, r1_b, r1_acc;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        mul_start, mul_done, busy;
    logic [31:0] mul_in0, mul_in1, mul_acc0, mul_result;

    mult_sched dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_acc(r0_acc),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_acc(r1_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .mul_start(mul_start), .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_acc0(mul_acc0),
        .mul_done(mul_done), .mul_result(mul_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        id;
        logic [31:0] res;
        int          acc_cyc;
        int          exp_lat;
        bit          zero;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Multiplier model: start edge clears done, done registered k+1 edges later
    function automatic int iters(input logic [31:0] v);
        int p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        return (p + 2) / 2;
    endfunction

    logic m_run = 1'b0;
    int   m_cnt = 0;
    initial begin
        mul_done   = 1'b0;
        mul_result = 32'd0;
    end
    always @(posedge clk) begin
        if (mul_start) begin
            m_run      <= 1'b1;
            mul_done   <= 1'b0;
            m_cnt      <= iters(mul_in0) + 1;
            mul_result <= mul_in0 * mul_in1 + mul_acc0;
            start_cnt  <= start_cnt + 1;
        end else if (m_run) begin
            if (m_cnt == 1) begin
                mul_done <= 1'b1;
                m_run    <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    // Monitor: pops the scoreboard on every response handshake
    bit seen = 0;
    int first_cyc = 0;
    bit prev_start = 0;
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (mul_start) check("start_single_cycle", {31'd0, prev_start}, 32'd0);
        prev_start = mul_start;
        if (rst) begin
            seen = 0;
        end else if (rsp_valid) begin
            if (!seen) begin
                seen      = 1;
                first_cyc = cyc;
            end
            if (rsp_ready) begin
                seen = 0;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
                end else begin
                    e   = sb.pop_front();
                    lat = first_cyc - e.acc_cyc;
                    check("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                    check("rsp_result", rsp_result, e.res);
                    if (e.zero) check("zero_latency_le1", (lat <= 1) ? 32'd1 : 32'd0, 32'd1);
                    else        check("latency", lat, e.exp_lat);
                end
            end
        end
    end

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] acc, input logic [31:0] exp_res,
                         input logic [31:0] exp_in0, input logic [31:0] exp_in1,
                         input int exp_lat, input bit push);
        bit   got = 0;
        bit   zero;
        exp_t e;
        zero = (a == 32'd0) || (b == 32'd0);
        @(negedge clk);
        if (id == 1'b0) begin r0_valid = 1; r0_a = a; r0_b = b; r0_acc = acc; end
        else            begin r1_valid = 1; r1_a = a; r1_b = b; r1_acc = acc; end
        for (int t = 0; t < 300 && !got; t++) begin
            #1;
            if ((id == 1'b0) ? r0_ready : r1_ready) got = 1;
            else @(negedge clk);
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            e.id = id; e.res = exp_res; e.acc_cyc = cyc + 1; e.exp_lat = exp_lat; e.zero = zero;
            if (push) sb.push_back(e);
            grant_log.push_back(id);
            @(posedge clk);
            #1;
            @(negedge clk);
            if (zero) begin
                check("zero_no_start", {31'd0, mul_start}, 32'd0);
            end else begin
                check("start_pulse", {31'd0, mul_start}, 32'd1);
                check("mul_in0", mul_in0, exp_in0);
                check("mul_in1", mul_in1, exp_in1);
                check("mul_acc0", mul_acc0, acc);
            end
        end
        if (id == 1'b0) r0_valid = 0;
        else            r1_valid = 0;
    endtask

    task automatic drain();
        bit done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            if (sb.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int s0;
        rst = 1; rsp_ready = 1;
        r0_valid = 1; r0_a = 32'd3; r0_b = 32'd5; r0_acc = 0;
        r1_valid = 0; r1_a = 0; r1_b = 0; r1_acc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_mul_start", {31'd0, mul_start}, 32'd0);
        check("reset_r0_ready", {31'd0, r0_ready}, 32'd0);
        check("reset_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("reset_rsp_result", rsp_result, 32'd0);
        check("reset_mul_in0", mul_in0, 32'd0);
        check("reset_mul_in1", mul_in1, 32'd0);
        check("reset_mul_acc0", mul_acc0, 32'd0);
        r0_valid = 0;
        rst = 0;

        issue(0, 32'd3, 32'd5, 32'd7, 32'd22, 32'd3, 32'd5, 4, 1);
        drain();
        issue(1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFF, 4, 1);
        drain();
        issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 19, 1);
        drain();

        grant_log.delete();
        fork
            begin
                issue(0, 32'd6, 32'd7, 32'd1, 32'd43, 32'd6, 32'd7, 5, 1);
                issue(0, 32'd10, 32'd4, 32'd0, 32'd40, 32'd4, 32'd10, 5, 1);
            end
            begin
                issue(1, 32'd3, 32'd100, 32'd0, 32'd300, 32'd3, 32'd100, 4, 1);
                issue(1, 32'h1_0000, 32'h1_0000, 32'd5, 32'd5, 32'h1_0000, 32'h1_0000, 12, 1);
            end
        join
        drain();
        check("grant_count", grant_log.size(), 32'd4);
        if (grant_log.size() == 4) begin
            check("grant0", {31'd0, grant_log[0]}, 32'd0);
            check("grant1", {31'd0, grant_log[1]}, 32'd1);
            check("grant2", {31'd0, grant_log[2]}, 32'd0);
            check("grant3", {31'd0, grant_log[3]}, 32'd1);
        end

        s0 = start_cnt;
        issue(0, 32'd0, 32'd9, 32'h1234, 32'h1234, 32'd0, 32'd0, 1, 1);
        drain();
        check("zero_skip_start_count", start_cnt, s0);

        rsp_ready = 0;
        issue(0, 32'd12, 32'd11, 32'd0, 32'd132, 32'd11, 32'd12, 5, 1);
        for (int t = 0; t < 50 && !rsp_valid; t++) @(negedge clk);
        check("hold_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        r1_valid = 1; r1_a = 32'd2; r1_b = 32'd3; r1_acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rsp_result", rsp_result, 32'd132);
            check("hold_r0_ready", {31'd0, r0_ready}, 32'd0);
            check("hold_r1_ready", {31'd0, r1_ready}, 32'd0);
        end
        r1_valid = 0;
        rsp_ready = 1;
        drain();

        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 19, 0);
        repeat (5) @(negedge clk);
        check("wait_busy", {31'd0, busy}, 32'd1);
        rst = 1;
        @(negedge clk);
        check("rst_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_wait_busy", {31'd0, busy}, 32'd0);
        check("rst_wait_mul_start", {31'd0, mul_start}, 32'd0);
        rst = 0;
        issue(0, 32'd2, 32'd2, 32'd0, 32'd4, 32'd2, 32'd2, 4, 1);
        drain();
        repeat (25) @(negedge clk);
        check("no_stale_rsp", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_sched.md
# mult_sched

Multiply sequencer and arbiter in the Execute stage. It shares the single iterative radix-4 `Multiplier` between two requesters. Port 0 is the Execute multiply path and port 1 is the spare port, reserved for the coprocessor/long-multiply path. The block arbitrates round-robin, shortens operations by ordering operands and skipping zero operands, drives the multiplier's one-cycle `start` pulse, waits for `done`, and returns a tagged result over a valid/ready response channel.

## Interface
Parameters:
- none (widths fixed at 32 bits, two requesters)

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst`  in  1  reset, synchronous, active-high
- `r0_valid`  in  1  requester 0 has an operation
- `r0_ready`  out  1  requester 0 accepted this cycle
- `r0_a`, `r0_b`, `r0_acc`  in  32 each  operands and accumulator (result = a*b + acc, mod 2^32)
- `r1_valid`, `r1_ready`, `r1_a`, `r1_b`, `r1_acc`  same, requester 1
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer takes result
- `rsp_id`  out  1  requester that owns the result
- `rsp_result`  out  32  a*b + acc
- `mul_start`  out  1  one-cycle start pulse to `Multiplier`
- `mul_in0`, `mul_in1`, `mul_acc0`  out  32 each  multiplier operands; `mul_in0` is the bitfield/iteration operand
- `mul_done`  in  1  multiplier done flag
- `mul_result`  in  32  multiplier result
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE:
  - `rN_ready` = `rN_valid` & grant(N), combinational.
  - Only one grant per cycle.
  - If both requesters are valid, the one not granted last wins.
  - The round-robin pointer updates only on acceptance.
- On acceptance: latch `a`, `b`, `acc`, id.
  - If `a`==0 or `b`==0: result = `acc`, go to RESP. This is the zero-skip path; the multiplier is untouched.
  - Otherwise go to START. `mul_in0` = unsigned min(a,b) and `mul_in1` = max(a,b), since fewer significant bits in `in0` means fewer iterations.
- START:
  - `mul_start`=1 for exactly this cycle, then go to WAIT.
  - The multiplier clears `done` on this edge, so a stale `done` from a previous operation is never sampled.
- WAIT:
  - `mul_start`=0.
  - On `mul_done`=1, capture `mul_result` into the response register and go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_id` and `rsp_result` are held stable.
  - On `rsp_ready`, go to IDLE. There is no new acceptance in that same cycle.
- `mul_in0`, `mul_in1`, `mul_acc0` are driven from the latched registers and stay stable from START through WAIT.
- Reset values:
  - state IDLE; round-robin pointer favours r0.
  - `mul_start`=0, `rsp_valid`=0, `busy`=0, `rN_ready`=0.
  - `rsp_id`=0, `rsp_result`=0, `mul_in*`/`mul_acc0`=0.
- Reset mid-operation: abandon the operation, drop any pending response, go to IDLE. A `mul_done` arriving later is ignored because it is only sampled in WAIT.

## Timing
- Let p = index of the highest set bit of `mul_in0`, and k = ceil((p+1)/2), the number of multiplier iterations.
- Normal path: accept at edge A; `rsp_valid` is high after edge A+k+3.
  - Edge A+1: start edge.
  - Edge A+k+2: `done` registered.
  - Edge A+k+3: capture.
  - Minimum latency is 4 edges (k=1); maximum is 19 edges (k=16).
- Zero-skip path: `rsp_valid` is high after edge A+1.
- Throughput: next acceptance no earlier than the cycle after the `rsp_valid`&&`rsp_ready` edge.
- `rsp_ready` held low: stay in RESP indefinitely and keep outputs stable. Both `rN_ready` stay 0.
- `mul_start` is never high for two consecutive cycles.

## Test plan
- Reset, then r0: a=3, b=5, acc=7 -> `rsp_result`=22, `rsp_id`=0. `mul_in0`=3, `mul_in1`=5. `rsp_valid` after edge A+4.
- r1: a=0xFFFFFFFF, b=2, acc=0 -> operands swapped (`mul_in0`=2), `rsp_result`=0xFFFFFFFE, latency 4 edges. Then a=b=0xFFFFFFFF, acc=1 -> `rsp_result`=2, latency 19 edges.
- r0 and r1 valid simultaneously for 4 operations -> grants alternate 0,1,0,1. Each `rsp_id` matches and no request is lost.
- r0: a=0, b=9, acc=0x1234 -> `rsp_result`=0x1234 after edge A+1, `mul_start` never asserted.
- Hold `rsp_ready`=0 for 10 cycles -> `rsp_valid`/`rsp_result` stable and `rN_ready`=0. Assert `rst` during WAIT -> next cycle `rsp_valid`=0, `busy`=0, `mul_start`=0, and a subsequent a=2, b=2, acc=0 returns 4.
